// File: rtl/start_token_fifo_srl_if.sv
`default_nettype none
// ============================================================================
// Module      : start_token_fifo_srl_if
// Description : Producer/consumer handshake bundle for start_token_fifo_srl.
//               The slave modport is the FIFO side; the master modport is the
//               side that drives writes and reads.
// Revision    : 1.0 - initial release
// ============================================================================
interface start_token_fifo_srl_if #(
    parameter int DATA_WIDTH = 1,
    parameter int ADDR_WIDTH = 1
) ();

    logic                  if_write_ce;
    logic                  if_write;
    logic [DATA_WIDTH-1:0] if_din;
    logic                  if_full_n;
    logic                  if_read_ce;
    logic                  if_read;
    logic [DATA_WIDTH-1:0] if_dout;
    logic                  if_empty_n;
    logic [ADDR_WIDTH:0]   if_count;

    modport slave (
        input  if_write_ce,
        input  if_write,
        input  if_din,
        output if_full_n,
        input  if_read_ce,
        input  if_read,
        output if_dout,
        output if_empty_n,
        output if_count
    );

    modport master (
        output if_write_ce,
        output if_write,
        output if_din,
        input  if_full_n,
        output if_read_ce,
        output if_read,
        input  if_dout,
        input  if_empty_n,
        input  if_count
    );

endinterface
`default_nettype wire

// File: rtl/start_token_fifo_srl.sv
`default_nettype none
// ============================================================================
// Module      : start_token_fifo_srl
// Description : Single-clock shift-register FIFO for start tokens / narrow
//               data. Writes shift in at index 0; the read port addresses the
//               oldest entry (show-ahead). Full/empty flags are registered and
//               computed from the next-state occupancy.
// Revision    : 1.0 - initial release
// ============================================================================
module start_token_fifo_srl #(
    parameter int DATA_WIDTH = 1,
    parameter int ADDR_WIDTH = 1,
    parameter int DEPTH      = 2
) (
    input  wire logic clk,
    input  wire logic reset,
    start_token_fifo_srl_if.slave bus
);

    localparam logic [ADDR_WIDTH:0] c_depth = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] c_one   = {{ADDR_WIDTH{1'b0}}, 1'b1};
    localparam logic [ADDR_WIDTH:0] c_zero  = '0;

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [ADDR_WIDTH:0]   r_count;
    logic                  r_empty_n;
    logic                  r_full_n;

    logic                  w_push;
    logic                  w_pop;
    logic [ADDR_WIDTH:0]   w_count_next;
    logic [ADDR_WIDTH:0]   w_count_m1;
    logic [ADDR_WIDTH-1:0] w_addr;

    // Requests only fire against the registered flags; a reset cycle
    // swallows any transfer so storage cannot shift while being cleared.
    assign w_push = ~reset & bus.if_write & bus.if_write_ce & r_full_n;
    assign w_pop  = ~reset & bus.if_read  & bus.if_read_ce  & r_empty_n;

    // Next-state occupancy; simultaneous push and pop leaves it unchanged.
    always_comb begin
        w_count_next = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_next = r_count + c_one;
            2'b01:   w_count_next = r_count - c_one;
            default: w_count_next = r_count;
        endcase
    end

    // Occupancy and flags update together, so flags carry no extra latency.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_count   <= c_zero;
            r_empty_n <= 1'b0;
            r_full_n  <= 1'b1;
        end else begin
            r_count   <= w_count_next;
            r_empty_n <= (w_count_next != c_zero);
            r_full_n  <= (w_count_next != c_depth);
        end
    end

    // Shift-register storage: no reset, moves only when a word is accepted.
    always_ff @(posedge clk) begin
        if (w_push) begin
            for (int i = DEPTH - 1; i > 0; i--) begin
                r_mem[i] <= r_mem[i-1];
            end
            r_mem[0] <= bus.if_din;
        end
    end

    // The oldest word sits at index count-1; index 0 when empty (don't-care).
    assign w_count_m1 = r_count - c_one;
    assign w_addr     = (r_count != c_zero) ? w_count_m1[ADDR_WIDTH-1:0] : '0;

    assign bus.if_dout    = r_mem[w_addr];
    assign bus.if_empty_n = r_empty_n;
    assign bus.if_full_n  = r_full_n;
    assign bus.if_count   = r_count;

endmodule
`default_nettype wire

// File: tb/tb_start_token_fifo_srl.sv
`default_nettype none
// ============================================================================
// Module      : tb_start_token_fifo_srl
// Description : Self-checking bench for start_token_fifo_srl. Directed tests
//               on a DEPTH=2 instance, random traffic on a DEPTH=4 instance.
//               Accepted writes are pushed to per-instance queues; monitors
//               compare popped data and flags against those queues.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_start_token_fifo_srl;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    start_token_fifo_srl_if #(.DATA_WIDTH(8), .ADDR_WIDTH(1)) bus_a ();
    start_token_fifo_srl_if #(.DATA_WIDTH(8), .ADDR_WIDTH(2)) bus_b ();

    start_token_fifo_srl #(.DATA_WIDTH(8), .ADDR_WIDTH(1), .DEPTH(2)) dut_a (
        .clk   (clk),
        .reset (rst),
        .bus   (bus_a.slave)
    );

    start_token_fifo_srl #(.DATA_WIDTH(8), .ADDR_WIDTH(2), .DEPTH(4)) dut_b (
        .clk   (clk),
        .reset (rst),
        .bus   (bus_b.slave)
    );

    int   n_cmp = 0;
    int   n_bad = 0;
    bit   mon_on = 1'b0;
    logic [7:0] qa [$];
    logic [7:0] qb [$];
    bit   wa, ra, wb, rb;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard queue A: an accepted write pushes its word, a fired read pops.
    always @(posedge clk) begin
        if (rst) begin
            qa.delete();
        end else begin
            wa = bus_a.if_write && bus_a.if_write_ce && (qa.size() < 2);
            ra = bus_a.if_read  && bus_a.if_read_ce  && (qa.size() > 0);
            if (ra) void'(qa.pop_front());
            if (wa) qa.push_back(bus_a.if_din);
        end
    end

    // Scoreboard queue B (DEPTH=4).
    always @(posedge clk) begin
        if (rst) begin
            qb.delete();
        end else begin
            wb = bus_b.if_write && bus_b.if_write_ce && (qb.size() < 4);
            rb = bus_b.if_read  && bus_b.if_read_ce  && (qb.size() > 0);
            if (rb) void'(qb.pop_front());
            if (wb) qb.push_back(bus_b.if_din);
        end
    end

    // Monitor A: mid-cycle flag/count checks and data check on each pop.
    always @(negedge clk) begin
        if (mon_on && !rst) begin
            chk("a_count",   32'(bus_a.if_count), 32'(qa.size()));
            chk("a_empty_n", 32'(bus_a.if_empty_n), 32'(qa.size() != 0));
            chk("a_full_n",  32'(bus_a.if_full_n),  32'(qa.size() != 2));
            if (bus_a.if_read && bus_a.if_read_ce && qa.size() > 0)
                chk("a_pop_data", 32'(bus_a.if_dout), 32'(qa[0]));
        end
    end

    // Monitor B.
    always @(negedge clk) begin
        if (mon_on && !rst) begin
            chk("b_count",   32'(bus_b.if_count), 32'(qb.size()));
            chk("b_empty_n", 32'(bus_b.if_empty_n), 32'(qb.size() != 0));
            chk("b_full_n",  32'(bus_b.if_full_n),  32'(qb.size() != 4));
            if (bus_b.if_read && bus_b.if_read_ce && qb.size() > 0)
                chk("b_pop_data", 32'(bus_b.if_dout), 32'(qb[0]));
        end
    end

    // Directed stimulus on A, then random traffic on B.
    initial begin
        bus_a.if_write_ce = 1'b1; bus_a.if_write = 1'b0; bus_a.if_din = 8'h00;
        bus_a.if_read_ce  = 1'b1; bus_a.if_read  = 1'b0;
        bus_b.if_write_ce = 1'b1; bus_b.if_write = 1'b0; bus_b.if_din = 8'h00;
        bus_b.if_read_ce  = 1'b1; bus_b.if_read  = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        mon_on = 1'b1;

        // Reset state, then a read while empty changes nothing.
        chk("t1_count",   32'(bus_a.if_count),   32'd0);
        chk("t1_empty_n", 32'(bus_a.if_empty_n), 32'd0);
        chk("t1_full_n",  32'(bus_a.if_full_n),  32'd1);
        bus_a.if_read = 1'b1;
        tick();
        bus_a.if_read = 1'b0;
        chk("t1_rd_empty_count", 32'(bus_a.if_count),   32'd0);
        chk("t1_rd_empty_n",     32'(bus_a.if_empty_n), 32'd0);

        // Fill then drain; the third write is dropped.
        bus_a.if_write = 1'b1; bus_a.if_din = 8'hA1;
        tick();
        chk("t2_head_after_1", 32'(bus_a.if_dout), 32'h0A1);
        bus_a.if_din = 8'hB2;
        tick();
        chk("t2_full_n", 32'(bus_a.if_full_n), 32'd0);
        chk("t2_count",  32'(bus_a.if_count),  32'd2);
        chk("t2_head",   32'(bus_a.if_dout),   32'h0A1);
        bus_a.if_din = 8'hC3;
        tick();
        bus_a.if_write = 1'b0;
        chk("t2_drop_count", 32'(bus_a.if_count), 32'd2);
        chk("t2_drop_head",  32'(bus_a.if_dout),  32'h0A1);
        bus_a.if_read = 1'b1;
        tick();
        chk("t2_rd1_head",  32'(bus_a.if_dout),  32'h0B2);
        chk("t2_rd1_count", 32'(bus_a.if_count), 32'd1);
        tick();
        bus_a.if_read = 1'b0;
        chk("t2_rd2_count",   32'(bus_a.if_count),   32'd0);
        chk("t2_rd2_empty_n", 32'(bus_a.if_empty_n), 32'd0);
        chk("t2_rd2_full_n",  32'(bus_a.if_full_n),  32'd1);

        // Push and pop together at count 1.
        bus_a.if_write = 1'b1; bus_a.if_din = 8'h11;
        tick();
        bus_a.if_din = 8'h22; bus_a.if_read = 1'b1;
        tick();
        bus_a.if_write = 1'b0; bus_a.if_read = 1'b0;
        chk("t3_count",   32'(bus_a.if_count),   32'd1);
        chk("t3_head",    32'(bus_a.if_dout),    32'h022);
        chk("t3_empty_n", 32'(bus_a.if_empty_n), 32'd1);

        // Clock-enables low: requests are ignored.
        bus_a.if_write_ce = 1'b0; bus_a.if_read_ce = 1'b0;
        bus_a.if_write = 1'b1; bus_a.if_read = 1'b1; bus_a.if_din = 8'hEE;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("t4_count", 32'(bus_a.if_count), 32'd1);
            chk("t4_head",  32'(bus_a.if_dout),  32'h022);
        end
        bus_a.if_write = 1'b0; bus_a.if_read = 1'b0;
        bus_a.if_write_ce = 1'b1; bus_a.if_read_ce = 1'b1;

        // Mid-operation reset at count 2, with a write in the reset cycle.
        bus_a.if_write = 1'b1; bus_a.if_din = 8'h33;
        tick();
        chk("t5_pre_count", 32'(bus_a.if_count), 32'd2);
        rst = 1'b1; bus_a.if_din = 8'h44;
        tick();
        rst = 1'b0;
        chk("t5_rst_count",   32'(bus_a.if_count),   32'd0);
        chk("t5_rst_empty_n", 32'(bus_a.if_empty_n), 32'd0);
        chk("t5_rst_full_n",  32'(bus_a.if_full_n),  32'd1);
        bus_a.if_din = 8'h5A;
        tick();
        bus_a.if_write = 1'b0;
        chk("t5_head",  32'(bus_a.if_dout),  32'h05A);
        chk("t5_count", 32'(bus_a.if_count), 32'd1);
        bus_a.if_read = 1'b1;
        tick();
        bus_a.if_read = 1'b0;

        // Random traffic on the DEPTH=4 instance.
        for (int i = 0; i < 1000; i++) begin
            bus_b.if_write = 1'($urandom_range(0, 1));
            bus_b.if_read  = 1'($urandom_range(0, 1));
            bus_b.if_din   = 8'($urandom_range(0, 255));
            tick();
        end
        bus_b.if_write = 1'b0;
        bus_b.if_read  = 1'b1;
        repeat (5) tick();
        bus_b.if_read  = 1'b0;
        tick();
        chk("t6_drained_count", 32'(bus_b.if_count), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Hard time limit so the run always ends.
    initial begin
        #200000;
        n_bad++;
        $display("FAIL watchdog: got timeout, expected completion");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/start_token_fifo_srl.md
Name: start_token_fifo_srl

Overview:
- Single-clock, SRL-based handshake FIFO carrying start tokens (or narrow data) from a producing dataflow process to a consuming process such as a PE instance.
- Owns both ends of the buffer: a write port for the producer and a read port for the consumer.
- Storage is an internal shift-register array: writes shift new data in at index 0, and the read port selects the oldest entry by address.
- Exposes full/empty flags and an occupancy count for the dataflow scheduler and debug.

Parameters:
- DATA_WIDTH, 1, payload width in bits.
- ADDR_WIDTH, 1, read-address width; must satisfy 2**ADDR_WIDTH >= DEPTH.
- DEPTH, 2, number of entries; legal range is DEPTH >= 2.

Ports:
- clk  input  1  sole clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- if_write_ce  input  1  write clock-enable; when 0, the write port is ignored.
- if_write  input  1  producer write request.
- if_din  input  DATA_WIDTH  write data.
- if_full_n  output  1  1 = at least one free entry.
- if_read_ce  input  1  read clock-enable; when 0, the read port is ignored.
- if_read  input  1  consumer read request (pop).
- if_dout  output  DATA_WIDTH  oldest stored entry (show-ahead).
- if_empty_n  output  1  1 = at least one valid entry.
- if_count  output  ADDR_WIDTH+1  current occupancy, 0..DEPTH.

Behaviour:
- Internal state:
  - count register, ADDR_WIDTH+1 bits.
  - Storage array mem[0..DEPTH-1], DATA_WIDTH each.
- Fire conditions:
  - push = if_write & if_write_ce & if_full_n.
  - pop = if_read & if_read_ce & if_empty_n.
  - Requests while full (write) or empty (read) are dropped; no state change, no error.
- Storage update:
  - On push: mem[i+1] <= mem[i] for i = 0..DEPTH-2, then mem[0] <= if_din.
  - Storage is not reset, and it does not shift unless push is true.
- Occupancy update:
  - push only: count +1.
  - pop only: count -1.
  - push and pop together: count unchanged, shift still occurs.
  - neither: hold.
- Flags are registered, derived from the next-state count:
  - if_empty_n <= (count_next != 0).
  - if_full_n <= (count_next != DEPTH).
  - Both flags update in the same cycle as count; there is no extra flag latency.
- Read address and output:
  - addr = count-1 when count > 0, else 0.
  - if_dout = mem[addr], combinational from registered state.
  - Read latency: data written at edge N is visible on if_dout and flagged by if_empty_n=1 after edge N (zero-cycle show-ahead).
  - if_dout is don't-care while if_empty_n=0; it must not be X-checked there.
- Simultaneous push and pop at count==DEPTH is impossible, since push requires if_full_n=1. At count==DEPTH-1 both fire and the FIFO stays at DEPTH-1.
- Simultaneous push and pop at count==1: the new word becomes the head after the edge, and if_empty_n stays 1.
- Reset, including mid-operation: at the next edge count=0, if_empty_n=0, if_full_n=1, if_count=0. Any push or pop in the reset cycle is discarded.
- No combinational path from if_write/if_read to if_full_n/if_empty_n.

Test Plan:
1. Reset then idle (DEPTH=2, DATA_WIDTH=8) -> if_empty_n=0, if_full_n=1, if_count=0. Read request while empty -> no change.
2. Fill then drain:
   - Write 0xA1, 0xB2 on consecutive cycles -> after the 2nd edge if_full_n=0, if_count=2, if_dout=0xA1.
   - A third write of 0xC3 is dropped.
   - Two reads return 0xA1, then 0xB2; the FIFO ends empty.
3. Simultaneous push/pop at count=1 (holding 0x11), writing 0x22 -> count stays 1, if_dout=0x22, if_empty_n=1.
4. Clock-enable gating: if_write=1 with if_write_ce=0, and if_read=1 with if_read_ce=0 -> count and data unchanged for 5 cycles.
5. Mid-operation reset with count=2 -> next edge count=0, empty; a write of 0x5A in the next cycle appears at if_dout with count=1.
6. Random traffic (DEPTH=4, 1000 cycles, 50% write and read probability) -> output order matches a scoreboard queue, flags consistent with if_count every cycle, and no write accepted while full.
